synchro_counter_updown: RTL and testbench

- Parametrised successor to the 8-bit synchronous set/reset counter.
- Runs entirely on the quartz clock and counts edges of an asynchronous tick input (clk_in).
- Adds configurable width, up/down direction, a selectable counting edge, an input synchroniser, and distinct single-cycle carry/borrow pulses.
- Used for display scanning, generation counters and prescaler chains in the Game of Life datapath.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 49 ++++
 rtl/synchro_counter_updown.sv | 118 +++++++++++
 tb/tb_synchro_counter_updown.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the synchronised up/down counter family.
package counter_pkg;

  // Counting-edge selections for sync_edge_detect.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // up_down encodings.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest in-range count (M-1). limit==0 selects the full 2^width range,
  // whose M-1 is the all-ones value of the given width.
  function automatic logic [31:0] mod_max(input logic [31:0] limit, input int unsigned width);
    logic [31:0] ones;
    ones = (32'd1 << width) - 32'd1;
    if (limit == 32'd0) begin
      mod_max = ones;
    end else begin
      mod_max = limit - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse on the
// selected edge(s) of an asynchronous input.
module sync_edge_detect
  import counter_pkg::*;
#(
  parameter int unsigned EDGE_SEL = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic event_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift the async input through the synchroniser; s3 remembers the previous s2.
  always_comb begin
    s1_d = async_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Edge event selection.
  always_comb begin
    event_o = 1'b0;
    if (EDGE_SEL == EDGE_FALL) begin
      event_o = ~s2_q & s3_q;
    end else if (EDGE_SEL == EDGE_BOTH) begin
      event_o = s2_q ^ s3_q;
    end else begin
      event_o = s2_q & ~s3_q;
    end
  end

endmodule

// File: rtl/synchro_counter_updown.sv
// Parametrised up/down counter of asynchronous clk_in edges, clocked by qzt_clk.
// Optional registered Gray-code output enabled by SYNCHRO_COUNTER_GRAY_OUT_EN.
module synchro_counter_updown
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned EDGE_SEL = EDGE_RISE
) (
  input  logic             qzt_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH-1:0] preset_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow,
  output logic             terminal
`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] out_gray
`endif
);

  logic             count_event;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  sync_edge_detect #(
    .EDGE_SEL(EDGE_SEL)
  ) u_edge (
    .clk_i  (qzt_clk),
    .rst_ni (reset),
    .async_i(clk_in),
    .event_o(count_event)
  );

  assign max_val = WIDTH'(mod_max(32'(limit), WIDTH));

  // Next count: clear > set > enabled event > hold; pulses default low.
  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (set) begin
      cnt_d = preset_value;
    end else if (count_event && enable) begin
      if (up_down == DIR_UP) begin
        // >= also folds an out-of-range preset back to 0.
        if (cnt_q >= max_val) begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d    = max_val;
          borrow_d = 1'b1;
        end else if (cnt_q > max_val) begin
          // Out-of-range value snaps to the top without a borrow.
          cnt_d = max_val;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and pulse registers.
  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Outputs; terminal tracks the current direction and limit.
  always_comb begin
    out      = cnt_q;
    carry    = carry_q;
    borrow   = borrow_q;
    terminal = (up_down == DIR_UP) ? (cnt_q == max_val) : (cnt_q == '0);
  end

`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q, gray_d;

  // Gray code of the next count so it lands on the same edge as out.
  always_comb begin
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  // Gray output register.
  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign out_gray = gray_q;
`endif

endmodule

// File: tb/tb_synchro_counter_updown.sv
// Randomised and directed bench for synchro_counter_updown: an 8-bit rising-edge
// instance and a 4-bit both-edge instance share the control inputs.
module tb_synchro_counter_updown;

  logic       qzt_clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_in = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic       set = 1'b0;
  logic [7:0] preset8 = '0, limit8 = '0, out8;
  logic [3:0] preset4 = '0, limit4 = '0, out4;
  logic       carry8, borrow8, term8, carry4, borrow4, term4;
`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
  logic [7:0] gray8;
  logic [3:0] gray4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 qzt_clk = ~qzt_clk;

  synchro_counter_updown #(.WIDTH(8), .EDGE_SEL(0)) dut8 (
    .qzt_clk(qzt_clk), .reset(reset), .clk_in(clk_in), .enable(enable),
    .up_down(up_down), .clear(clear), .set(set), .preset_value(preset8),
    .limit(limit8), .out(out8), .carry(carry8), .borrow(borrow8), .terminal(term8)
`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
    , .out_gray(gray8)
`endif
  );

  synchro_counter_updown #(.WIDTH(4), .EDGE_SEL(2)) dut4 (
    .qzt_clk(qzt_clk), .reset(reset), .clk_in(clk_in), .enable(enable),
    .up_down(up_down), .clear(clear), .set(set), .preset_value(preset4),
    .limit(limit4), .out(out4), .carry(carry4), .borrow(borrow4), .terminal(term4)
`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
    , .out_gray(gray4)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule for one qzt_clk edge, in plain integer arithmetic.
  function automatic void step(input int cur, input bit ev, input int lim, input int full,
                               input int pre, output int nxt, output bit cy, output bit bw);
    int m;
    m   = (lim == 0) ? full : lim;
    nxt = cur;
    cy  = 1'b0;
    bw  = 1'b0;
    if (clear) nxt = 0;
    else if (set) nxt = pre;
    else if (ev && enable) begin
      if (up_down) begin
        if (cur >= m - 1) begin nxt = 0; cy = 1'b1; end
        else nxt = cur + 1;
      end else begin
        if (cur == 0) begin nxt = m - 1; bw = 1'b1; end
        else if (cur >= m) nxt = m - 1;
        else nxt = cur - 1;
      end
    end
  endfunction

  // Model state: clk_in values seen at the last three qzt_clk edges.
  bit hist [3];
  int m8_out, m4_out;
  bit m8_cy, m8_bw, m4_cy, m4_bw;

  initial begin
    forever begin
      @(posedge qzt_clk or negedge reset);
      if (!reset) begin
        hist = '{0, 0, 0};
        m8_out = 0; m8_cy = 0; m8_bw = 0;
        m4_out = 0; m4_cy = 0; m4_bw = 0;
      end else begin
        int n8, n4;
        bit c8, b8, c4, b4;
        // An input change becomes an event two edges after it is first sampled.
        step(m8_out, hist[1] & ~hist[2], int'(limit8), 256, int'(preset8), n8, c8, b8);
        step(m4_out, hist[1] ^ hist[2], int'(limit4), 16, int'(preset4), n4, c4, b4);
        m8_out = n8; m8_cy = c8; m8_bw = b8;
        m4_out = n4; m4_cy = c4; m4_bw = b4;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = clk_in;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge qzt_clk) begin
    if (reset) begin
      int top8, top4;
      top8 = (limit8 == 0) ? 255 : int'(limit8) - 1;
      top4 = (limit4 == 0) ? 15 : int'(limit4) - 1;
      chk("out8", int'(out8), m8_out);
      chk("carry8", int'(carry8), int'(m8_cy));
      chk("borrow8", int'(borrow8), int'(m8_bw));
      chk("term8", int'(term8), up_down ? int'(m8_out == top8) : int'(m8_out == 0));
      chk("out4", int'(out4), m4_out);
      chk("carry4", int'(carry4), int'(m4_cy));
      chk("borrow4", int'(borrow4), int'(m4_bw));
      chk("term4", int'(term4), up_down ? int'(m4_out == top4) : int'(m4_out == 0));
`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
      chk("gray8", int'(gray8), m8_out ^ (m8_out >> 1));
      chk("gray4", int'(gray4), m4_out ^ (m4_out >> 1));
`endif
    end
  end

  // Raise clk_in and stop on the negedge just after the third qzt_clk edge.
  task automatic rise();
    clk_in = 1'b1;
    repeat (3) @(negedge qzt_clk);
  endtask

  task automatic fall();
    #1 clk_in = 1'b0;
    repeat (3) @(negedge qzt_clk);
    #1;
  endtask

  task automatic pulse_ctl(input bit c, input bit s, input logic [7:0] p8);
    clear = c; set = s; preset8 = p8;
    @(negedge qzt_clk);
    #1 clear = 1'b0; set = 1'b0;
  endtask

  int exp1 [6] = '{1, 2, 3, 4, 0, 1};
  int gray_exp [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int cy_seen;

  initial begin
    repeat (2) @(negedge qzt_clk);
    chk("reset_out8", int'(out8), 0);
    chk("reset_carry8", int'(carry8), 0);
    #1 reset = 1'b1; enable = 1'b1; up_down = 1'b1; limit8 = 8'd5;

    // Up count with limit 5, checking the three-edge latency.
    for (int i = 0; i < 6; i++) begin
      int prev;
      prev = int'(out8);
      clk_in = 1'b1;
      repeat (2) @(negedge qzt_clk);
      chk("latency_hold", int'(out8), prev);
      @(negedge qzt_clk);
      chk("up_seq", int'(out8), exp1[i]);
      chk("up_carry", int'(carry8), (i == 4) ? 1 : 0);
      fall();
    end

    // Down wrap from 0, then count down to 0.
    pulse_ctl(1'b1, 1'b0, 8'd0);
    up_down = 1'b0;
    rise();
    chk("down_wrap", int'(out8), 4);
    chk("down_borrow", int'(borrow8), 1);
    chk("down_term", int'(term8), 0);
    fall();
    for (int i = 0; i < 4; i++) begin rise(); fall(); end
    chk("down_zero", int'(out8), 0);
    chk("down_term0", int'(term8), 1);

    // Clear and set together with a coinciding event.
    up_down = 1'b1;
    pulse_ctl(1'b0, 1'b1, 8'd2);
    clk_in = 1'b1;
    repeat (2) @(negedge qzt_clk);
    #1 clear = 1'b1; set = 1'b1; preset8 = 8'd3;
    @(negedge qzt_clk);
    chk("prio_out", int'(out8), 0);
    chk("prio_carry", int'(carry8), 0);
    #1 clear = 1'b0; set = 1'b0;
    repeat (2) @(negedge qzt_clk);
    chk("prio_discard", int'(out8), 0);
    fall();
    rise();
    chk("prio_next", int'(out8), 1);
    fall();

    // Disabled events are dropped.
    enable = 1'b0;
    rise();
    chk("dis_hold", int'(out8), 1);
    fall();
    enable = 1'b1;

    // Out-of-range preset resolved by the next event.
    limit8 = 8'd10;
    pulse_ctl(1'b0, 1'b1, 8'd200);
    chk("oor_load", int'(out8), 200);
    rise();
    chk("oor_up", int'(out8), 0);
    chk("oor_carry", int'(carry8), 1);
    fall();
    pulse_ctl(1'b0, 1'b1, 8'd200);
    up_down = 1'b0;
    rise();
    chk("oor_down", int'(out8), 9);
    chk("oor_borrow", int'(borrow8), 0);
    fall();

    // Full range, both edges: 16 events from 0 wrap once.
    up_down = 1'b1; limit4 = 4'd0;
    pulse_ctl(1'b1, 1'b0, 8'd0);
    cy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      clk_in = 1'b1;
      repeat (3) begin @(negedge qzt_clk); cy_seen += int'(carry4); end
      #1 clk_in = 1'b0;
      repeat (3) begin @(negedge qzt_clk); cy_seen += int'(carry4); end
      #1;
    end
    chk("full_wrap", int'(out4), 0);
    chk("full_carries", cy_seen, 1);
    rise();
    chk("both_one", int'(out4), 1);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0; clk_in = 1'b0;
    #1;
    chk("async_out4", int'(out4), 0);
    chk("async_out8", int'(out8), 0);
    @(negedge qzt_clk);
    #1 reset = 1'b1;

`ifdef SYNCHRO_COUNTER_GRAY_OUT_EN
    limit8 = 8'd0; up_down = 1'b1;
    pulse_ctl(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      chk("gray_seq", int'(gray8), gray_exp[i]);
      rise(); fall();
    end
`endif

    // Randomised phase; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge qzt_clk);
      #1;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
      if ($urandom_range(0, 2) == 0) clk_in = ~clk_in;
      enable = ($urandom_range(0, 7) != 0);
      up_down = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 59) == 0);
      set = ($urandom_range(0, 39) == 0);
      preset8 = 8'($urandom);
      preset4 = 4'($urandom);
      if ($urandom_range(0, 99) == 0) limit8 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 99) == 0) limit4 = 4'($urandom);
    end

    @(negedge qzt_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
